exec_writeback_unit: RTL and testbench

- Execute stage directly upstream of the 8x16 register file; consumes the two source operands read from it and produces the write port (tgt, tgt_dat) that feeds back into it.
- Single-cycle ALU ops plus a bit-serial shifter (one bit per cycle), with a valid/ready handshake to the decode/issue logic.
- The register file writes every clock unconditionally; register 0 reads as zero. This block therefore steers tgt to 0 on every cycle with no real writeback.

---
 rtl/exec_writeback_unit.sv | 175 +++++++++++++++++
 tb/tb_exec_writeback_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/exec_writeback_unit.sv
// Execute/writeback stage: single-cycle ALU ops plus a bit-serial shifter.
// Optional shift-add multiplier (op 1000) is built when EXEC_MUL_EN is defined.
module exec_writeback_unit #(
  parameter int WIDTH   = 16,
  parameter int RADDR_W = 3,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   src1_dat,
  input  logic [WIDTH-1:0]   src2_dat,
  input  logic [RADDR_W-1:0] dst,
  output logic [RADDR_W-1:0] tgt,
  output logic [WIDTH-1:0]   tgt_dat,
  output logic               wb_valid,
  output logic               busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE, SHIFT, WB, MUL} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, WB} state_e;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [1:0]         kind_q, kind_d;
  logic [RADDR_W-1:0] dst_q, dst_d;
  logic [RADDR_W-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0]   tgt_dat_q, tgt_dat_d;
  logic               wb_valid_q, wb_valid_d;
`ifdef EXEC_MUL_EN
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   acc_q, acc_d, acc_nxt;
`endif

  logic [WIDTH-1:0]   alu_res, sh_nxt;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;

  assign shamt    = src2_dat[SHAMT_W-1:0];
  assign is_shift = (op == 4'b0101) || (op == 4'b0110) || (op == 4'b0111);

  // Reserved ops fall through to ADD; a zero-amount shift passes src1 through.
  always_comb begin
    alu_res = src1_dat + src2_dat;
    case (op)
      4'b0001: alu_res = src1_dat - src2_dat;
      4'b0010: alu_res = src1_dat & src2_dat;
      4'b0011: alu_res = src1_dat | src2_dat;
      4'b0100: alu_res = src1_dat ^ src2_dat;
      4'b0101, 4'b0110, 4'b0111: alu_res = src1_dat;
      default: alu_res = src1_dat + src2_dat;
    endcase
  end

  always_comb begin
    case (kind_q)
      2'b01:   sh_nxt = {opa_q[WIDTH-2:0], 1'b0};
      2'b10:   sh_nxt = {1'b0, opa_q[WIDTH-1:1]};
      default: sh_nxt = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
    endcase
  end

`ifdef EXEC_MUL_EN
  assign acc_nxt = acc_q + (opb_q[0] ? opa_q : '0);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opa_d      = opa_q;
    kind_d     = kind_q;
    dst_d      = dst_q;
    tgt_d      = '0;
    tgt_dat_d  = '0;
    wb_valid_d = 1'b0;
`ifdef EXEC_MUL_EN
    opb_d      = opb_q;
    acc_d      = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d  = src1_dat;
          kind_d = op[1:0];
          dst_d  = dst;
          if (is_shift && (shamt != '0)) begin
            state_d = SHIFT;
            cnt_d   = CNT_W'(shamt);
`ifdef EXEC_MUL_EN
          end else if (op == 4'b1000) begin
            state_d = MUL;
            cnt_d   = CNT_W'(WIDTH);
            opb_d   = src2_dat;
            acc_d   = '0;
`endif
          end else begin
            // Reserved ops still pulse wb_valid but aim at the zero register.
            tgt_d      = op[3] ? '0 : dst;
            tgt_dat_d  = alu_res;
            wb_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        opa_d = sh_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = WB;
          tgt_d      = dst_q;
          tgt_dat_d  = sh_nxt;
          wb_valid_d = 1'b1;
        end
      end
`ifdef EXEC_MUL_EN
      MUL: begin
        acc_d = acc_nxt;
        opa_d = {opa_q[WIDTH-2:0], 1'b0};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = WB;
          tgt_d      = dst_q;
          tgt_dat_d  = acc_nxt;
          wb_valid_d = 1'b1;
        end
      end
`endif
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opa_q      <= '0;
      kind_q     <= '0;
      dst_q      <= '0;
      tgt_q      <= '0;
      tgt_dat_q  <= '0;
      wb_valid_q <= 1'b0;
`ifdef EXEC_MUL_EN
      opb_q      <= '0;
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opa_q      <= opa_d;
      kind_q     <= kind_d;
      dst_q      <= dst_d;
      tgt_q      <= tgt_d;
      tgt_dat_q  <= tgt_dat_d;
      wb_valid_q <= wb_valid_d;
`ifdef EXEC_MUL_EN
      opb_q      <= opb_d;
      acc_q      <= acc_d;
`endif
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tgt      = tgt_q;
  assign tgt_dat  = tgt_dat_q;
  assign wb_valid = wb_valid_q;
endmodule

// File: tb/tb_exec_writeback_unit.sv
// Scoreboard bench for exec_writeback_unit: stimulus pushes expected writebacks,
// a negedge monitor pops and checks target, data and arrival cycle.
module tb_exec_writeback_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] src1_dat, src2_dat;
  logic [2:0]  dst;
  logic [2:0]  tgt;
  logic [15:0] tgt_dat;
  logic        wb_valid;
  logic        busy;

  exec_writeback_unit #(.WIDTH(16), .RADDR_W(3), .SHAMT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1_dat(src1_dat), .src2_dat(src2_dat), .dst(dst), .tgt(tgt),
    .tgt_dat(tgt_dat), .wb_valid(wb_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle either a scoreboarded writeback or a harmless idle write.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        if (q.size() == 0) begin
          check("unexpected_wb", {29'd0, tgt}, 32'hDEAD);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("wb_tgt", {29'd0, tgt}, {29'd0, e.t});
          check("wb_dat", {16'd0, tgt_dat}, {16'd0, e.d});
          check("wb_cycle", cyc, e.cyc);
        end
      end else begin
        check("idle_tgt", {29'd0, tgt}, 32'd0);
        check("idle_dat", {16'd0, tgt_dat}, 32'd0);
      end
    end
  end

  // Called one step after a rising edge; returns one step after the accept edge.
  task automatic issue(logic [3:0] o, logic [15:0] a, logic [15:0] b, logic [2:0] d,
                       logic [2:0] et, logic [15:0] ed, int lat, bit push);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) check("ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; src1_dat = a; src2_dat = b; dst = d;
    @(posedge clk); #1;
    if (push) q.push_back('{et, ed, cyc + lat - 1});
    in_valid = 1'b0;
    src1_dat = 16'h5A5A; src2_dat = 16'hA5A5; dst = 3'd7; op = 4'h0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; op = 4'h0;
    src1_dat = 16'hFFFF; src2_dat = 16'h0002; dst = 3'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tgt", {29'd0, tgt}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_tgt", {29'd0, tgt}, 32'd0);
    check("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // back-to-back single-cycle ops
    issue(4'b0000, 16'hFFFF, 16'h0002, 3'd3, 3'd3, 16'h0001, 1, 1'b1);
    issue(4'b0001, 16'h0005, 16'h0007, 3'd4, 3'd4, 16'hFFFE, 1, 1'b1);
    issue(4'b0010, 16'hF0F0, 16'h3C3C, 3'd2, 3'd2, 16'h3030, 1, 1'b1);
    issue(4'b0011, 16'hF000, 16'h000F, 3'd1, 3'd1, 16'hF00F, 1, 1'b1);
    repeat (2) @(posedge clk); #1;

    // SRA by 4: in_ready low for 5 cycles
    issue(4'b0111, 16'h8000, 16'h0004, 3'd5, 3'd5, 16'hF800, 5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("sra_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("sra_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("sra_in_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    issue(4'b0110, 16'h8000, 16'h0004, 3'd5, 3'd5, 16'h0800, 5, 1'b1);
    issue(4'b0101, 16'h0001, 16'h000F, 3'd6, 3'd6, 16'h8000, 16, 1'b1);
    issue(4'b0111, 16'h4000, 16'h0003, 3'd2, 3'd2, 16'h0800, 4, 1'b1);

    // shift by 0 (amount bits zero) is single-cycle; dst=0 still pulses
    issue(4'b0101, 16'h1234, 16'h0010, 3'd7, 3'd7, 16'h1234, 1, 1'b1);
    issue(4'b0100, 16'hAAAA, 16'h5555, 3'd0, 3'd0, 16'hFFFF, 1, 1'b1);
    repeat (3) @(posedge clk); #1;

    // reset two cycles into an SLL by 8: writeback must be dropped
    issue(4'b0101, 16'h0001, 16'h0008, 3'd2, 3'd0, 16'h0000, 9, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
    repeat (10) @(posedge clk); #1;
    issue(4'b0000, 16'h0001, 16'h0001, 3'd1, 3'd1, 16'h0002, 1, 1'b1);
    @(posedge clk); #1;

    // reserved ops behave as ADD with tgt forced to 0
    issue(4'b1111, 16'h0001, 16'h0001, 3'd5, 3'd0, 16'h0002, 1, 1'b1);
`ifdef EXEC_MUL_EN
    issue(4'b1000, 16'h0123, 16'h0010, 3'd2, 3'd2, 16'h1230, 17, 1'b1);
    issue(4'b1000, 16'h00FF, 16'h0101, 3'd3, 3'd3, 16'hFFFF, 17, 1'b1);
`else
    issue(4'b1000, 16'h0123, 16'h0010, 3'd2, 3'd0, 16'h0133, 1, 1'b1);
`endif

    for (int w = 0; w < 100 && q.size() != 0; w++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
